perm_sequencer: RTL and testbench

- Iterative controller that sits directly upstream of the combinational `permutator`.
- Accepts a `scBusSize`-bit word over a valid/ready handshake and applies a programmed sequence of up to `progDepth` permutation codes, one per clock.
- Drives the permutator's `in`/`cntrl` pins each step and registers its `out` back into an accumulator.
- Returns the final word over a second valid/ready handshake.

---
 rtl/perm_sequencer_if.sv | 38 +++
 rtl/perm_sequencer.sv | 107 ++++++++++
 tb/tb_perm_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/perm_sequencer_if.sv
// Handshake, program-write and permutator-facing signal bundle for perm_sequencer.
// slave: the sequencer itself; master: whatever feeds jobs and hosts the permutator.
interface perm_sequencer_if #(
    parameter int scBusSize = 37,
    parameter int cntrlSize = 4,
    parameter int progDepth = 8
);
    localparam int AW = $clog2(progDepth);
    localparam int SW = AW + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [scBusSize-1:0] in_data;
    logic [SW-1:0]        num_steps;
    logic                 prog_we;
    logic [AW-1:0]        prog_addr;
    logic [cntrlSize-1:0] prog_data;
    logic [scBusSize-1:0] perm_in;
    logic [cntrlSize-1:0] perm_cntrl;
    logic [scBusSize-1:0] perm_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [scBusSize-1:0] out_data;
    logic [scBusSize-1:0] out_chk;
    logic                 busy;

    modport slave (
        input  in_valid, in_data, num_steps, prog_we, prog_addr, prog_data,
               perm_out, out_ready,
        output in_ready, perm_in, perm_cntrl, out_valid, out_data, out_chk, busy
    );

    modport master (
        output in_valid, in_data, num_steps, prog_we, prog_addr, prog_data,
               perm_out, out_ready,
        input  in_ready, perm_in, perm_cntrl, out_valid, out_data, out_chk, busy
    );
endinterface

// File: rtl/perm_sequencer.sv
// Iterative driver for the combinational permutator: runs up to progDepth programmed codes per word.
// Optional XOR checksum of intermediates enabled by defining PERM_SEQ_CHECKSUM_EN.
module perm_sequencer #(
    parameter int scBusSize = 37,
    parameter int cntrlSize = 4,
    parameter int progDepth = 8
) (
    input logic             clk,
    input logic             rst,
    perm_sequencer_if.slave bus
);
    localparam int AW = $clog2(progDepth);
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] DEPTH = SW'(progDepth);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [scBusSize-1:0] acc_reg, acc_next;
    logic [SW-1:0]        step_reg, step_next;
    logic [SW-1:0]        len_reg, len_next;
    logic [SW-1:0]        clamped_steps;
    logic                 accept;
    logic [cntrlSize-1:0] prog [progDepth];

    assign clamped_steps = (bus.num_steps > DEPTH) ? DEPTH : bus.num_steps;
    assign accept        = (state_reg == ST_IDLE) && bus.in_valid;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        step_next  = step_reg;
        len_next   = len_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    acc_next   = bus.in_data;
                    step_next  = '0;
                    len_next   = clamped_steps;
                    state_next = (clamped_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                acc_next  = bus.perm_out;
                step_next = step_reg + SW'(1);
                if (step_reg == len_reg - SW'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            step_reg  <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            step_reg  <= step_next;
            len_reg   <= len_next;
        end
    end

    // Program memory is deliberately unreset; writes are locked out while a job is in flight.
    always_ff @(posedge clk) begin
        if (bus.prog_we && state_reg == ST_IDLE) begin
            prog[bus.prog_addr] <= bus.prog_data;
        end
    end

`ifdef PERM_SEQ_CHECKSUM_EN
    logic [scBusSize-1:0] chk_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_reg <= '0;
        end else if (accept) begin
            chk_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            chk_reg <= chk_reg ^ bus.perm_out;
        end
    end

    assign bus.out_chk = chk_reg;
`else
    assign bus.out_chk = '0;
`endif

    // After a full-depth run step wraps to progDepth; the truncated index then points at entry 0.
    assign bus.perm_in    = acc_reg;
    assign bus.perm_cntrl = prog[step_reg[AW-1:0]];
    assign bus.out_data   = acc_reg;
    assign bus.in_ready   = (state_reg == ST_IDLE);
    assign bus.out_valid  = (state_reg == ST_DONE);
    assign bus.busy       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_perm_sequencer.sv
// Self-checking bench for perm_sequencer with a behavioural permutator (code 0 = invert, c = rotate left by c).
module tb_perm_sequencer;
    localparam int W  = 37;
    localparam int C  = 4;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int SW = 4;

    typedef struct {
        logic [W-1:0] din;
        int           n;
        logic [C-1:0] p0;
        logic [C-1:0] p1;
        logic [C-1:0] p2;
        logic [W-1:0] exp_data;
        logic [W-1:0] exp_chk;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [C-1:0] model_prog [D];

    always #5 clk = ~clk;

    perm_sequencer_if #(.scBusSize(W), .cntrlSize(C), .progDepth(D)) bus ();

    perm_sequencer #(.scBusSize(W), .cntrlSize(C), .progDepth(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] permute(input logic [W-1:0] x, input logic [C-1:0] c);
        logic [W-1:0] r;
        if (c == '0) return ~x;
        r = x;
        for (int i = 0; i < int'(c); i++) r = {r[W-2:0], r[W-1]};
        return r;
    endfunction

    always_comb bus.perm_out = permute(bus.perm_in, bus.perm_cntrl);

    function automatic logic [W-1:0] chk_exp(input logic [W-1:0] x);
`ifdef PERM_SEQ_CHECKSUM_EN
        return x;
`else
        return '0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_job(input logic [W-1:0] din, input int n,
                           output logic [W-1:0] res, output logic [W-1:0] chk);
        int m;
        m   = (n > D) ? D : n;
        res = din;
        chk = '0;
        for (int i = 0; i < m; i++) begin
            res = permute(res, model_prog[i]);
            chk = chk ^ res;
        end
        chk = chk_exp(chk);
    endtask

    task automatic write_prog(input int a, input logic [C-1:0] d);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = AW'(a);
        bus.prog_data = d;
        @(negedge clk);
        bus.prog_we   = 1'b0;
        model_prog[a] = d;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_job(input string name, input logic [W-1:0] din, input int n,
                           input logic [W-1:0] exp_data, input logic [W-1:0] exp_chk);
        int lat;
        int m;
        m = (n > D) ? D : n;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = din;
        bus.num_steps = SW'(n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check({name, "_latency"}, 64'(lat), 64'(m));
        check({name, "_data"}, 64'(bus.out_data), 64'(exp_data));
        check({name, "_chk"}, 64'(bus.out_chk), 64'(exp_chk));
        check({name, "_busy"}, 64'(bus.busy), 64'd1);
        check({name, "_in_ready_done"}, 64'(bus.in_ready), 64'd0);
        $display("job %s: din=%h n=%0d out=%h chk=%h lat=%0d", name, din, n, bus.out_data, bus.out_chk, lat);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, "_released"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        logic [W-1:0] din, res, chk, held;
        int n, lat;

        vecs[0] = '{din: 37'h1,            n: 3, p0: 4'd1, p1: 4'd1, p2: 4'd1, exp_data: 37'h8,            exp_chk: 37'hE};
        vecs[1] = '{din: 37'h12345,        n: 0, p0: 4'd1, p1: 4'd1, p2: 4'd1, exp_data: 37'h12345,        exp_chk: 37'h0};
        vecs[2] = '{din: 37'h0,            n: 2, p0: 4'd0, p1: 4'd0, p2: 4'd5, exp_data: 37'h0,            exp_chk: 37'h1F_FFFF_FFFF};
        vecs[3] = '{din: 37'h1,            n: 2, p0: 4'd2, p1: 4'd0, p2: 4'd5, exp_data: 37'h1F_FFFF_FFFB, exp_chk: 37'h1F_FFFF_FFFF};
        vecs[4] = '{din: 37'h10_0000_0000, n: 1, p0: 4'd3, p1: 4'd3, p2: 4'd3, exp_data: 37'h4,            exp_chk: 37'h4};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.num_steps = '0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_chk", 64'(bus.out_chk), 64'd0);
        check("rst_perm_in", 64'(bus.perm_in), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < D; i++) write_prog(i, C'($urandom_range(0, 15)));
        @(negedge clk);
        check("idle_perm_cntrl", 64'(bus.perm_cntrl), 64'(model_prog[0]));

        // Table vectors
        for (int v = 0; v < 5; v++) begin
            write_prog(0, vecs[v].p0);
            write_prog(1, vecs[v].p1);
            write_prog(2, vecs[v].p2);
            run_job($sformatf("vec%0d", v), vecs[v].din, vecs[v].n, vecs[v].exp_data, chk_exp(vecs[v].exp_chk));
        end

        // Backpressure: result held, input refused, next job only after release
        write_prog(0, 4'd1);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 37'h1; bus.num_steps = SW'(1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd1);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = k[0]; bus.in_data = 37'h7; bus.num_steps = SW'(0);
            @(negedge clk);
            check("bp_data", 64'(bus.out_data), 64'h2);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 37'h5; bus.num_steps = SW'(0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_release_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_next_valid", 64'(bus.out_valid), 64'd1);
        check("bp_next_data", 64'(bus.out_data), 64'h5);
        check("bp_next_chk", 64'(bus.out_chk), 64'd0);
        $display("job bp_next: din=%h n=0 out=%h", 37'h5, bus.out_data);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Program write during RUN is ignored
        write_prog(0, 4'd1);
        write_prog(1, 4'd1);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 37'h1; bus.num_steps = SW'(2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.prog_we = 1'b1; bus.prog_addr = AW'(1); bus.prog_data = 4'd0;
        @(negedge clk);
        bus.prog_we = 1'b0;
        check("runwr_cntrl", 64'(bus.perm_cntrl), 64'd1);
        wait_valid(lat);
        check("runwr_data", 64'(bus.out_data), 64'h4);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        run_job("runwr_again", 37'h1, 2, 37'h4, chk_exp(37'h6));

        // Program write in the acceptance cycle is used by that job
        @(negedge clk);
        bus.prog_we = 1'b1; bus.prog_addr = AW'(0); bus.prog_data = 4'd2;
        bus.in_valid = 1'b1; bus.in_data = 37'h1; bus.num_steps = SW'(1);
        model_prog[0] = 4'd2;
        @(negedge clk);
        bus.prog_we = 1'b0; bus.in_valid = 1'b0;
        wait_valid(lat);
        check("samecyc_latency", 64'(lat), 64'd1);
        check("samecyc_data", 64'(bus.out_data), 64'h4);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset at step 2 of a 5-step job aborts it
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 37'h3; bus.num_steps = SW'(5);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_out_data", 64'(bus.out_data), 64'd0);
        check("abort_out_chk", 64'(bus.out_chk), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(bus.out_valid), 64'd0);
        end
        ref_job(37'h3, 5, res, chk);
        run_job("after_abort", 37'h3, 5, res, chk);

        // Randomized jobs against the reference model, including clamped step counts
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) write_prog($urandom_range(0, D - 1), C'($urandom_range(0, 15)));
            din  = W'({$urandom(), $urandom()});
            n    = $urandom_range(0, 15);
            ref_job(din, n, res, chk);
            run_job($sformatf("rand%0d", t), din, n, res, chk);
        end

        // Back-to-back full-depth jobs with out_ready held high
        bus.out_ready = 1'b1;
        held = 37'h1_2345_6789;
        ref_job(held, D, res, chk);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = held; bus.num_steps = SW'(D);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("full_latency", 64'(lat), 64'(D));
        check("full_data", 64'(bus.out_data), 64'(res));
        @(negedge clk);
        check("full_released", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
